// File: rtl/alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// alu_ctrl_seq
//   Registered ALU control unit. Decodes ALUop / function_code into alu_ctr
//   behind a valid/ready handshake and sequences the multi-cycle operations
//   (multiply, optional divide) with an internal down-counter.
//
//   Optional feature macro: ALU_CTRL_DIV_EN
//     defined   : funct 011010 decodes to div (1001), DIV_CYCLES latency
//     undefined : funct 011010 decodes as illegal (1111), 1-cycle latency
//
// Ports
//   clk, rst_n      : clock, synchronous active-low reset
//   in_valid/ready  : op handshake from decode (ALUop, function_code)
//   out_valid/ready : result handshake to the ALU (alu_ctr, illegal)
//   busy            : a multi-cycle op is executing
// ---------------------------------------------------------------------------
module alu_ctrl_seq #(
    parameter int FUNCT_W    = 6,
    parameter int ALUOP_W    = 3,
    parameter int CTR_W      = 4,
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [FUNCT_W-1:0] function_code,
    input  logic [ALUOP_W-1:0] ALUop,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTR_W-1:0]   alu_ctr,
    output logic               illegal,
    output logic               busy
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_SLT = 4'b0111;
    localparam logic [3:0] C_MUL = 4'b1000;
`ifdef ALU_CTRL_DIV_EN
    localparam logic [3:0] C_DIV = 4'b1001;
`endif
    localparam logic [3:0] C_NOR = 4'b1100;
    localparam logic [3:0] C_ILL = 4'b1111;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_OUT} state_t;

    typedef struct packed {
        logic [3:0]       code;
        logic             ill;
        logic             multi;
        logic [CNT_W-1:0] load;
    } dec_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    dec_t             dec;
    logic             accept;

    // Decode is purely combinational; it is only captured on accept.
    always_comb begin
        dec.code  = C_ILL;
        dec.ill   = 1'b1;
        dec.multi = 1'b0;
        dec.load  = '0;
        // Any set bit above bit 2 leaves the op illegal.
        if ((ALUop >> 3) == '0) begin
            case (ALUop[2:0])
                3'b000: begin dec.code = C_ADD; dec.ill = 1'b0; end
                3'b001: begin dec.code = C_SUB; dec.ill = 1'b0; end
                3'b010: begin dec.code = C_AND; dec.ill = 1'b0; end
                3'b011: begin dec.code = C_OR;  dec.ill = 1'b0; end
                3'b100: begin dec.code = C_SLT; dec.ill = 1'b0; end
                3'b101: begin dec.code = C_NOR; dec.ill = 1'b0; end
                3'b111: begin
                    case (function_code)
                        FUNCT_W'(6'b100000): begin dec.code = C_ADD; dec.ill = 1'b0; end
                        FUNCT_W'(6'b100010): begin dec.code = C_SUB; dec.ill = 1'b0; end
                        FUNCT_W'(6'b100100): begin dec.code = C_AND; dec.ill = 1'b0; end
                        FUNCT_W'(6'b100101): begin dec.code = C_OR;  dec.ill = 1'b0; end
                        FUNCT_W'(6'b100111): begin dec.code = C_NOR; dec.ill = 1'b0; end
                        FUNCT_W'(6'b101010): begin dec.code = C_SLT; dec.ill = 1'b0; end
                        FUNCT_W'(6'b011000): begin
                            dec.code  = C_MUL;
                            dec.ill   = 1'b0;
                            dec.multi = 1'b1;
                            dec.load  = CNT_W'(MUL_CYCLES - 1);
                        end
`ifdef ALU_CTRL_DIV_EN
                        FUNCT_W'(6'b011010): begin
                            dec.code  = C_DIV;
                            dec.ill   = 1'b0;
                            dec.multi = 1'b1;
                            dec.load  = CNT_W'(DIV_CYCLES - 1);
                        end
`endif
                        default: ;
                    endcase
                end
                default: ; // 110 stays illegal
            endcase
        end
    end

    // in_ready is gated by rst_n so nothing is offered while reset is held.
    assign in_ready = rst_n && ((state == S_IDLE) || ((state == S_OUT) && out_ready));
    assign accept   = in_valid && in_ready;

    // cnt holds the number of BUSY cycles still to run including the current
    // one; leaving on cnt==1 gives N-1 busy cycles and the result at accept+N.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            alu_ctr   <= '0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_OUT: begin
                    if (accept) begin
                        alu_ctr <= CTR_W'(dec.code);
                        illegal <= dec.ill;
                        if (dec.multi) begin
                            state     <= S_BUSY;
                            cnt       <= dec.load;
                            busy      <= 1'b1;
                            out_valid <= 1'b0;
                        end else begin
                            state     <= S_OUT;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                        end
                    end else if (state == S_OUT && out_ready) begin
                        state     <= S_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state     <= S_OUT;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_ctrl_seq
//   Self-checking bench for alu_ctrl_seq. Accepted ops push their expected
//   result into a queue; each completed output handshake pops and compares.
//   Scenario tasks add inline checks of latency, busy and handshake timing.
// ---------------------------------------------------------------------------
module tb_alu_ctrl_seq;

    localparam int MUL_CYCLES = 4;
    localparam int DIV_CYCLES = 8;
`ifdef ALU_CTRL_DIV_EN
    localparam int DIV_LAT = DIV_CYCLES;
    localparam logic [3:0] DIV_CTR = 4'b1001;
    localparam logic DIV_ILL = 1'b0;
`else
    localparam int DIV_LAT = 1;
    localparam logic [3:0] DIV_CTR = 4'b1111;
    localparam logic DIV_ILL = 1'b1;
`endif

    localparam logic [3:0] STREAM_EXP [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};
    localparam logic [2:0] RT_OP  [3] = '{3'b111, 3'b111, 3'b110};
    localparam logic [5:0] RT_FN  [3] = '{6'b101010, 6'b000101, 6'b000000};
    localparam logic [3:0] RT_CTR [3] = '{4'b0111, 4'b1111, 4'b1111};
    localparam logic       RT_ILL [3] = '{1'b0, 1'b1, 1'b1};
    localparam logic [5:0] FN_LIST [10] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111,
                                           6'b101010, 6'b011000, 6'b011010, 6'b000101, 6'b111111};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic [5:0] function_code = '0;
    logic [2:0] ALUop = '0;
    logic       in_ready, out_valid, illegal, busy;
    logic [3:0] alu_ctr;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] ctr;
        logic       ill;
    } exp_t;

    exp_t sb[$];

    alu_ctrl_seq #(
        .FUNCT_W(6), .ALUOP_W(3), .CTR_W(4),
        .MUL_CYCLES(MUL_CYCLES), .DIV_CYCLES(DIV_CYCLES)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .function_code(function_code), .ALUop(ALUop),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_ctr(alu_ctr), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference decode, written from the opcode tables.
    function automatic exp_t model(input logic [2:0] op, input logic [5:0] fn);
        exp_t e;
        e.ctr = 4'b1111;
        e.ill = 1'b1;
        case (op)
            3'b000: e = '{4'b0010, 1'b0};
            3'b001: e = '{4'b0110, 1'b0};
            3'b010: e = '{4'b0000, 1'b0};
            3'b011: e = '{4'b0001, 1'b0};
            3'b100: e = '{4'b0111, 1'b0};
            3'b101: e = '{4'b1100, 1'b0};
            3'b111: begin
                case (fn)
                    6'b100000: e = '{4'b0010, 1'b0};
                    6'b100010: e = '{4'b0110, 1'b0};
                    6'b100100: e = '{4'b0000, 1'b0};
                    6'b100101: e = '{4'b0001, 1'b0};
                    6'b100111: e = '{4'b1100, 1'b0};
                    6'b101010: e = '{4'b0111, 1'b0};
                    6'b011000: e = '{4'b1000, 1'b0};
                    6'b011010: e = '{DIV_CTR, DIV_ILL};
                    default:   e = '{4'b1111, 1'b1};
                endcase
            end
            default: e = '{4'b1111, 1'b1};
        endcase
        return e;
    endfunction

    // Scoreboard: inputs are stable at the falling edge, so the handshakes
    // seen here are the ones the next rising edge will complete.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: output alu_ctr=%b illegal=%b with no op pending", alu_ctr, illegal);
                end else begin
                    e = sb.pop_front();
                    if (alu_ctr !== e.ctr || illegal !== e.ill) begin
                        failures++;
                        $display("FAIL sb_result: alu_ctr=%b illegal=%b, expected alu_ctr=%b illegal=%b",
                                 alu_ctr, illegal, e.ctr, e.ill);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(model(ALUop, function_code));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; ALUop = 3'b000; function_code = '0; out_ready = 1'b1;
        repeat (3) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b0 || alu_ctr !== 4'b0000 || busy !== 1'b0 || illegal !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold: out_valid=%b in_ready=%b alu_ctr=%b busy=%b illegal=%b, expected 0 0 0000 0 0",
                         out_valid, in_ready, alu_ctr, busy, illegal);
            end
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || alu_ctr !== 4'b0000 || busy !== 1'b0 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b alu_ctr=%b busy=%b illegal=%b, expected 1 0 0000 0 0",
                     in_ready, out_valid, alu_ctr, busy, illegal);
        end
    endtask

    task automatic test_stream();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; ALUop = 3'(i); function_code = '0;
            tick();
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || alu_ctr !== STREAM_EXP[i] || illegal !== 1'b0) begin
                failures++;
                $display("FAIL stream_%0d: out_valid=%b in_ready=%b alu_ctr=%b illegal=%b, expected 1 1 %b 0",
                         i, out_valid, in_ready, alu_ctr, illegal, STREAM_EXP[i]);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL stream_end: out_valid=%b, expected 0", out_valid);
        end
    endtask

    task automatic test_rtype_illegal();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; ALUop = RT_OP[i]; function_code = RT_FN[i];
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || alu_ctr !== RT_CTR[i] || illegal !== RT_ILL[i]) begin
                failures++;
                $display("FAIL rtype_%0d: out_valid=%b alu_ctr=%b illegal=%b, expected 1 %b %b",
                         i, out_valid, alu_ctr, illegal, RT_CTR[i], RT_ILL[i]);
            end
            tick();
        end
    endtask

    task automatic test_multiply();
        out_ready = 1'b1;
        in_valid = 1'b1; ALUop = 3'b111; function_code = 6'b011000;
        tick();
        // A follow-on add is offered throughout and must wait for the multiply.
        ALUop = 3'b000; function_code = '0;
        for (int c = 1; c < MUL_CYCLES; c++) begin
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || alu_ctr !== 4'b1000) begin
                failures++;
                $display("FAIL mul_busy_c%0d: busy=%b in_ready=%b out_valid=%b alu_ctr=%b, expected 1 0 0 1000",
                         c, busy, in_ready, out_valid, alu_ctr);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b0 || alu_ctr !== 4'b1000 || illegal !== 1'b0) begin
            failures++;
            $display("FAIL mul_done: out_valid=%b busy=%b alu_ctr=%b illegal=%b, expected 1 0 1000 0",
                     out_valid, busy, alu_ctr, illegal);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || alu_ctr !== 4'b0010) begin
            failures++;
            $display("FAIL mul_follow: out_valid=%b alu_ctr=%b, expected 1 0010", out_valid, alu_ctr);
        end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        in_valid = 1'b1; ALUop = 3'b001; function_code = '0;
        tick();
        ALUop = 3'b010;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || alu_ctr !== 4'b0110 || illegal !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b alu_ctr=%b, expected 1 0 0110", c, out_valid, in_ready, alu_ctr);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || alu_ctr !== 4'b0000) begin
            failures++;
            $display("FAIL bp_release: out_valid=%b alu_ctr=%b, expected 1 0000", out_valid, alu_ctr);
        end
        tick();
    endtask

    task automatic test_divide();
        out_ready = 1'b1;
        in_valid = 1'b1; ALUop = 3'b111; function_code = 6'b011010;
        tick();
        in_valid = 1'b0;
        for (int c = 1; c < DIV_LAT; c++) begin
            checks++;
            if (busy !== 1'b1 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL div_busy_c%0d: busy=%b out_valid=%b, expected 1 0", c, busy, out_valid);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b0 || alu_ctr !== DIV_CTR || illegal !== DIV_ILL) begin
            failures++;
            $display("FAIL div_done: out_valid=%b busy=%b alu_ctr=%b illegal=%b, expected 1 0 %b %b",
                     out_valid, busy, alu_ctr, illegal, DIV_CTR, DIV_ILL);
        end
        tick();
    endtask

    task automatic test_reset_mid_mul();
        out_ready = 1'b1;
        in_valid = 1'b1; ALUop = 3'b111; function_code = 6'b011000;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_after: busy=%b out_valid=%b in_ready=%b, expected 0 0 0", busy, out_valid, in_ready);
        end
        rst_n = 1'b1;
        for (int c = 0; c < MUL_CYCLES + 2; c++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
                failures++;
                $display("FAIL rstmid_quiet_%0d: out_valid=%b busy=%b in_ready=%b, expected 0 0 1", c, out_valid, busy, in_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        for (int c = 0; c < 120; c++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            ALUop         = 3'($urandom_range(0, 7));
            function_code = FN_LIST[$urandom_range(0, 9)];
            out_ready     = ($urandom_range(0, 3) != 0);
            tick();
            checks++;
            if (busy === 1'b1 && out_valid === 1'b1) begin
                failures++;
                $display("FAIL b2b_excl_%0d: busy=%b out_valid=%b, expected not both 1", c, busy, out_valid);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while ((out_valid !== 1'b0 || busy !== 1'b0) && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_drain: out_valid=%b busy=%b after %0d cycles, expected 0 0", out_valid, busy, n);
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL b2b_pending: %0d ops never produced, expected 0", sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_rtype_illegal();
        test_multiply();
        test_backpressure();
        test_divide();
        test_reset_mid_mul();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
